// File: rtl/adc_seq_ctrl.sv
// Sequencer for the 8-bit serial ADC: frames chip-select setup, 8 MSB-first
// serial clocks and a conversion wait; the first frame after reset only primes the ADC.
module adc_seq_ctrl #(
  parameter int SCLK_DIV      = 25,
  parameter int CS_SETUP      = 75,
  parameter int CONV_WAIT     = 1000,
  parameter int SAMPLE_PERIOD = 2500
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic       start,
  input  logic       adc_data,
  output logic       adc_cs_n,
  output logic       adc_clk,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       busy,
  output logic       overrun
);

  localparam int CNT_MAX = (CS_SETUP > CONV_WAIT) ? CS_SETUP : CONV_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PH_W    = $clog2(2 * SCLK_DIV);
  localparam int TMR_W   = $clog2(SAMPLE_PERIOD);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, CONV} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [PH_W-1:0]    ph;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic               prime;
  logic               data_s1, data_s2;
  logic [TMR_W-1:0]   tmr;
  logic               tick;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_s1 <= 1'b0;
      data_s2 <= 1'b0;
    end else begin
      data_s1 <= adc_data;
      data_s2 <= data_s1;
    end
  end

  always_comb begin
    tick = en && (tmr == TMR_W'(SAMPLE_PERIOD - 1));
  end

  // Held at zero while disabled so the first tick lands a full period after en rises.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmr <= '0;
    end else if (!en || tick) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      ph         <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      prime      <= 1'b0;
      adc_cs_n   <= 1'b1;
      adc_clk    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      overrun    <= tick && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (start || tick) begin
            state    <= SETUP;
            cnt      <= '0;
            adc_cs_n <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == CNT_W'(CS_SETUP - 1)) begin
            state   <= SHIFT;
            cnt     <= '0;
            ph      <= '0;
            bit_idx <= 3'd7;
            adc_clk <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SHIFT: begin
          if (ph == '0) begin
            shreg[bit_idx] <= data_s2;
          end
          if (ph == PH_W'(SCLK_DIV - 1)) begin
            adc_clk <= 1'b0;
          end
          if (ph == PH_W'(2 * SCLK_DIV - 1)) begin
            ph <= '0;
            if (bit_idx == 3'd0) begin
              // Result is published on entry to DONE so the strobe occupies the DONE cycle.
              state    <= DONE;
              adc_cs_n <= 1'b1;
              if (prime) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx - 3'd1;
              adc_clk <= 1'b1;
            end
          end else begin
            ph <= ph + PH_W'(1);
          end
        end
        DONE: begin
          prime <= 1'b1;
          state <= CONV;
          cnt   <= '0;
        end
        CONV: begin
          if (cnt == CNT_W'(CONV_WAIT - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
